// File: rtl/keypad_scan_unit.sv
// rtl/keypad_scan_unit.sv - 4x4 keypad column scanner with frame-based debounce
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scan_unit #(
    parameter int CLK_DIV        = 8000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk_s,
    input  logic       rst_s,
    input  logic [3:0] row_k,
    output logic [3:0] col_k,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_DEBOUNCE = 2'd1;
    localparam logic [1:0]  ST_PRESSED  = 2'd2;
    localparam logic [1:0]  ST_RELEASE  = 2'd3;
    localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DEB_N       = 4'(DEBOUNCE_SCANS);

    if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("keypad_scan_unit: CLK_DIV out of range");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("keypad_scan_unit: DEBOUNCE_SCANS out of range");
    end
    if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_repeat
        $error("keypad_scan_unit: REPEAT_SCANS out of range");
    end

    logic [3:0]  row_meta, row_sync;
    logic [15:0] div_cnt;
    logic [1:0]  col_idx;
    logic [1:0]  acc_hits;
    logic [3:0]  acc_code;
    logic [1:0]  state;
    logic [3:0]  cand_code;
    logic [3:0]  cnt;
    logic [2:0]  col_cnt;
    logic [1:0]  col_row;
    logic [2:0]  frame_hits;
    logic [3:0]  frame_code;
    logic        sample, frame_end, f_none, f_single;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_N = 8'(REPEAT_SCANS);
    logic [7:0]  rep_cnt;
`endif

    function automatic logic [3:0] code_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: code_map = 4'h1;
            4'h1: code_map = 4'h2;
            4'h2: code_map = 4'h3;
            4'h3: code_map = 4'hA;
            4'h4: code_map = 4'h4;
            4'h5: code_map = 4'h5;
            4'h6: code_map = 4'h6;
            4'h7: code_map = 4'hB;
            4'h8: code_map = 4'h7;
            4'h9: code_map = 4'h8;
            4'hA: code_map = 4'h9;
            4'hB: code_map = 4'hC;
            4'hC: code_map = 4'hE;
            4'hD: code_map = 4'h0;
            4'hE: code_map = 4'hF;
            default: code_map = 4'hD;
        endcase
    endfunction

    // Hit count saturates at 2: only none / one / many matters for classification.
    always_comb begin
        col_cnt = 3'd0;
        col_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_cnt = col_cnt + 3'd1;
                col_row = 2'(r);
            end
        end
        frame_hits = {1'b0, acc_hits} + col_cnt;
        frame_code = (col_cnt == 3'd1) ? code_map(col_row, col_idx) : acc_code;
    end

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    assign f_none    = (frame_hits == 3'd0);
    assign f_single  = (frame_hits == 3'd1);
    assign key_held  = (state == ST_PRESSED) || (state == ST_RELEASE);

    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            div_cnt  <= '0;
            col_idx  <= '0;
            col_k    <= 4'b1110;
            acc_hits <= '0;
            acc_code <= '0;
        end else begin
            row_meta <= row_k;
            row_sync <= row_meta;
            if (sample) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                col_k   <= {col_k[2:0], col_k[3]};
                if (frame_end) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= (frame_hits >= 3'd2) ? 2'd2 : frame_hits[1:0];
                    acc_code <= frame_code;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand_code <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (f_single) begin
                            cand_code <= frame_code;
                            if (DEB_N == 4'd1) begin
                                state     <= ST_PRESSED;
                                key_code  <= frame_code;
                                key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
`endif
                            end else begin
                                state <= ST_DEBOUNCE;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (f_single && frame_code == cand_code) begin
                            if (cnt + 4'd1 == DEB_N) begin
                                state     <= ST_PRESSED;
                                cnt       <= '0;
                                key_code  <= cand_code;
                                key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
`endif
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // Other keys or multi-key frames are ignored until a clean release.
                        if (f_none) begin
                            if (DEB_N == 4'd1) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end else begin
                                state <= ST_RELEASE;
                                cnt   <= 4'd1;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_cnt + 8'd1 == REP_N) begin
                            rep_cnt   <= '0;
                            key_valid <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 8'd1;
                        end
`endif
                    end
                    default: begin
                        if (f_none) begin
                            if (cnt + 4'd1 == DEB_N) begin
                                state <= ST_IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end
                    end
                endcase
            end
        end
    end
endmodule
